// File: rtl/id_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_pipe_pkg
//  Description : Shared definitions for the decode/dispatch stage. Holds the
//                RV32I major opcodes, the internal op bus, and the decoded
//                entry record.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_pipe_pkg;

    localparam int OP_W  = 6;
    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef logic [OP_W-1:0] op_t;

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Internal op codes carried to the back end
    localparam op_t OP_NOP   = 6'd0;
    localparam op_t OP_LUI   = 6'd1;
    localparam op_t OP_AUIPC = 6'd2;
    localparam op_t OP_JAL   = 6'd3;
    localparam op_t OP_JALR  = 6'd4;
    localparam op_t OP_BEQ   = 6'd5;
    localparam op_t OP_BNE   = 6'd6;
    localparam op_t OP_BLT   = 6'd7;
    localparam op_t OP_BGE   = 6'd8;
    localparam op_t OP_BLTU  = 6'd9;
    localparam op_t OP_BGEU  = 6'd10;
    localparam op_t OP_LB    = 6'd11;
    localparam op_t OP_LH    = 6'd12;
    localparam op_t OP_LW    = 6'd13;
    localparam op_t OP_LBU   = 6'd14;
    localparam op_t OP_LHU   = 6'd15;
    localparam op_t OP_SB    = 6'd16;
    localparam op_t OP_SH    = 6'd17;
    localparam op_t OP_SW    = 6'd18;
    localparam op_t OP_ADDI  = 6'd19;
    localparam op_t OP_SLTI  = 6'd20;
    localparam op_t OP_SLTIU = 6'd21;
    localparam op_t OP_XORI  = 6'd22;
    localparam op_t OP_ORI   = 6'd23;
    localparam op_t OP_ANDI  = 6'd24;
    localparam op_t OP_SLLI  = 6'd25;
    localparam op_t OP_SRLI  = 6'd26;
    localparam op_t OP_SRAI  = 6'd27;
    localparam op_t OP_ADD   = 6'd28;
    localparam op_t OP_SUB   = 6'd29;
    localparam op_t OP_SLL   = 6'd30;
    localparam op_t OP_SLT   = 6'd31;
    localparam op_t OP_SLTU  = 6'd32;
    localparam op_t OP_XOR   = 6'd33;
    localparam op_t OP_SRL   = 6'd34;
    localparam op_t OP_SRA   = 6'd35;
    localparam op_t OP_OR    = 6'd36;
    localparam op_t OP_AND   = 6'd37;

    // Downstream structure an entry is dispatched to (ROB is always written)
    typedef enum logic [1:0] {
        CLS_RS  = 2'd0,
        CLS_LSB = 2'd1,
        CLS_ROB = 2'd2
    } cls_e;

    typedef struct packed {
        op_t              op;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] rd;
        logic             rd_en;
        logic [REG_W-1:0] rs1;
        logic             rs1_en;
        logic [REG_W-1:0] rs2;
        logic             rs2_en;
        cls_e             cls;
        logic             illegal;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/id_pipe_decode.sv
`default_nettype none
// ============================================================================
//  Module      : id_decode
//  Description : Purely combinational RV32I decoder. Produces internal op,
//                sign-extended immediate, register indices/enables, target
//                class and an illegal flag for one raw instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_decode
    import id_pipe_pkg::*;
(
    input  logic [31:0] inst_i,
    output dec_t        dec_o
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    logic        w_legal;
    op_t         w_op;
    logic [31:0] w_imm;
    logic        w_rd_wr;
    logic        w_rs1_use;
    logic        w_rs2_use;
    cls_e        w_cls;

    assign w_opc   = inst_i[6:0];
    assign w_f3    = inst_i[14:12];
    assign w_f7    = inst_i[31:25];
    assign w_imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign w_imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign w_imm_b = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign w_imm_u = {inst_i[31:12], 12'b0};
    assign w_imm_j = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    // Classify opcode/funct fields into an internal op and its operand usage
    always_comb begin
        w_legal   = 1'b0;
        w_op      = OP_NOP;
        w_imm     = '0;
        w_rd_wr   = 1'b0;
        w_rs1_use = 1'b0;
        w_rs2_use = 1'b0;
        w_cls     = CLS_RS;
        case (w_opc)
            OPC_LUI: begin
                w_legal = 1'b1; w_op = OP_LUI; w_imm = w_imm_u; w_rd_wr = 1'b1;
            end
            OPC_AUIPC: begin
                w_legal = 1'b1; w_op = OP_AUIPC; w_imm = w_imm_u; w_rd_wr = 1'b1;
            end
            OPC_JAL: begin
                w_legal = 1'b1; w_op = OP_JAL; w_imm = w_imm_j; w_rd_wr = 1'b1;
            end
            OPC_JALR: begin
                w_legal = (w_f3 == 3'b000); w_op = OP_JALR; w_imm = w_imm_i;
                w_rd_wr = 1'b1; w_rs1_use = 1'b1;
            end
            OPC_BRANCH: begin
                w_legal = 1'b1; w_imm = w_imm_b; w_rs1_use = 1'b1; w_rs2_use = 1'b1;
                case (w_f3)
                    3'b000:  w_op = OP_BEQ;
                    3'b001:  w_op = OP_BNE;
                    3'b100:  w_op = OP_BLT;
                    3'b101:  w_op = OP_BGE;
                    3'b110:  w_op = OP_BLTU;
                    3'b111:  w_op = OP_BGEU;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                w_legal = 1'b1; w_imm = w_imm_i; w_rd_wr = 1'b1; w_rs1_use = 1'b1;
                w_cls = CLS_LSB;
                case (w_f3)
                    3'b000:  w_op = OP_LB;
                    3'b001:  w_op = OP_LH;
                    3'b010:  w_op = OP_LW;
                    3'b100:  w_op = OP_LBU;
                    3'b101:  w_op = OP_LHU;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                w_legal = 1'b1; w_imm = w_imm_s; w_rs1_use = 1'b1; w_rs2_use = 1'b1;
                w_cls = CLS_LSB;
                case (w_f3)
                    3'b000:  w_op = OP_SB;
                    3'b001:  w_op = OP_SH;
                    3'b010:  w_op = OP_SW;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                w_legal = 1'b1; w_imm = w_imm_i; w_rd_wr = 1'b1; w_rs1_use = 1'b1;
                case (w_f3)
                    3'b000: w_op = OP_ADDI;
                    3'b010: w_op = OP_SLTI;
                    3'b011: w_op = OP_SLTIU;
                    3'b100: w_op = OP_XORI;
                    3'b110: w_op = OP_ORI;
                    3'b111: w_op = OP_ANDI;
                    3'b001: begin
                        w_op    = OP_SLLI;
                        w_legal = (w_f7 == 7'b0000000);
                    end
                    default: begin
                        // funct3 101: shamt shifts distinguished by funct7
                        w_op    = (w_f7 == 7'b0100000) ? OP_SRAI : OP_SRLI;
                        w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                    end
                endcase
            end
            OPC_OP: begin
                w_legal = 1'b1; w_rd_wr = 1'b1; w_rs1_use = 1'b1; w_rs2_use = 1'b1;
                case ({w_f7, w_f3})
                    10'b0000000_000: w_op = OP_ADD;
                    10'b0100000_000: w_op = OP_SUB;
                    10'b0000000_001: w_op = OP_SLL;
                    10'b0000000_010: w_op = OP_SLT;
                    10'b0000000_011: w_op = OP_SLTU;
                    10'b0000000_100: w_op = OP_XOR;
                    10'b0000000_101: w_op = OP_SRL;
                    10'b0100000_101: w_op = OP_SRA;
                    10'b0000000_110: w_op = OP_OR;
                    10'b0000000_111: w_op = OP_AND;
                    default:         w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Assemble the entry; illegal encodings collapse to a NOP owned by the ROB
    always_comb begin
        dec_o = '0;
        if (w_legal) begin
            dec_o.op     = w_op;
            dec_o.imm    = w_imm;
            dec_o.rd     = w_rd_wr ? inst_i[11:7] : 5'd0;
            dec_o.rd_en  = w_rd_wr && (inst_i[11:7] != 5'd0);
            dec_o.rs1    = w_rs1_use ? inst_i[19:15] : 5'd0;
            dec_o.rs1_en = w_rs1_use;
            dec_o.rs2    = w_rs2_use ? inst_i[24:20] : 5'd0;
            dec_o.rs2_en = w_rs2_use;
            dec_o.cls    = w_cls;
        end else begin
            dec_o.op      = OP_NOP;
            dec_o.cls     = CLS_ROB;
            dec_o.illegal = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : id_pipe
//  Description : Instruction decode stage. Decodes the offered instruction,
//                buffers decoded entries in a small FIFO and dispatches the
//                head to ROB plus RS or LSB when downstream has room.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_pipe #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int OP_W   = id_pipe_pkg::OP_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              iq_valid,
    input  logic [31:0]       iq_inst,
    input  logic [ADDR_W-1:0] iq_pc,
    output logic              iq_ready,
    input  logic              rob_full,
    input  logic              rs_full,
    input  logic              lsb_full,
    output logic              reg_rs1_en,
    output logic              reg_rs2_en,
    output logic [4:0]        reg_rs1,
    output logic [4:0]        reg_rs2,
    output logic              disp_valid,
    output logic [OP_W-1:0]   disp_op,
    output logic [31:0]       disp_imm,
    output logic [4:0]        disp_rd,
    output logic              disp_rd_en,
    output logic [ADDR_W-1:0] disp_pc,
    output logic              disp_illegal,
    output logic              rob_we,
    output logic              rs_we,
    output logic              lsb_we
);
    import id_pipe_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    dec_t              ent_q [DEPTH];
    logic [ADDR_W-1:0] pc_q  [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              live_q;

    dec_t              w_dec;
    dec_t              w_head;
    logic              w_push;
    logic              w_fire;
    logic              w_tgt_full;

    id_decode u_decode (
        .inst_i (iq_inst),
        .dec_o  (w_dec)
    );

    assign w_head = ent_q[head_q];

    // live_q holds off acceptance until the first edge after reset release
    assign iq_ready = live_q && (count_q < CNT_W'(DEPTH)) && rdy_in && !flush_in;
    assign w_push   = iq_valid && iq_ready;

    always_comb begin
        w_tgt_full = 1'b0;
        case (w_head.cls)
            CLS_RS:  w_tgt_full = rs_full;
            CLS_LSB: w_tgt_full = lsb_full;
            default: w_tgt_full = 1'b0;
        endcase
    end

    assign w_fire = (count_q != '0) && rdy_in && !flush_in && !rob_full && !w_tgt_full;

    assign disp_valid   = w_fire;
    assign rob_we       = w_fire;
    assign rs_we        = w_fire && (w_head.cls == CLS_RS);
    assign lsb_we       = w_fire && (w_head.cls == CLS_LSB);
    assign disp_op      = OP_W'(w_head.op);
    assign disp_imm     = w_head.imm;
    assign disp_rd      = w_head.rd;
    assign disp_rd_en   = w_head.rd_en;
    assign disp_pc      = pc_q[head_q];
    assign disp_illegal = w_head.illegal;
    assign reg_rs1_en   = w_head.rs1_en;
    assign reg_rs1      = w_head.rs1;
    assign reg_rs2_en   = w_head.rs2_en;
    assign reg_rs2      = w_head.rs2;

    // Entry storage: decoded fields and PC land in the tail slot on accept
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else if (w_push) begin
            ent_q[tail_q] <= w_dec;
            pc_q[tail_q]  <= iq_pc;
        end
    end

    // FIFO bookkeeping: flush wins, otherwise push/pop adjust pointers and count
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (w_push) tail_q <= tail_q + 1'b1;
                if (w_fire) head_q <= head_q + 1'b1;
                case ({w_push, w_fire})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Reset-release marker gating iq_ready
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) live_q <= 1'b0;
        else         live_q <= 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_id_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_pipe
//  Description : Self-checking bench for id_pipe. A table-driven RV32I
//                reference decoder and a queue model predict every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_pipe;
    import id_pipe_pkg::*;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 32;
    localparam int CL_RS  = 0;
    localparam int CL_LSB = 1;
    localparam int CL_ROB = 2;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in, flush_in, iq_valid;
    logic [31:0]       iq_inst;
    logic [ADDR_W-1:0] iq_pc;
    logic              iq_ready;
    logic              rob_full, rs_full, lsb_full;
    logic              reg_rs1_en, reg_rs2_en;
    logic [4:0]        reg_rs1, reg_rs2;
    logic              disp_valid;
    logic [5:0]        disp_op;
    logic [31:0]       disp_imm;
    logic [4:0]        disp_rd;
    logic              disp_rd_en;
    logic [ADDR_W-1:0] disp_pc;
    logic              disp_illegal;
    logic              rob_we, rs_we, lsb_we;

    id_pipe #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OP_W(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_ready(iq_ready),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .reg_rs1_en(reg_rs1_en), .reg_rs2_en(reg_rs2_en),
        .reg_rs1(reg_rs1), .reg_rs2(reg_rs2),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_imm(disp_imm),
        .disp_rd(disp_rd), .disp_rd_en(disp_rd_en), .disp_pc(disp_pc),
        .disp_illegal(disp_illegal),
        .rob_we(rob_we), .rs_we(rs_we), .lsb_we(lsb_we)
    );

    always #5 clk_in = ~clk_in;

    // ISA table row: an instruction matches when (inst & mask) == match
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [5:0]  op;
        byte         fmt;
    } row_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_en;
        logic [4:0]  rs1;
        logic        rs1_en;
        logic [4:0]  rs2;
        logic        rs2_en;
        logic [1:0]  cls;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [31:0]       inst;
        logic [ADDR_W-1:0] pc;
    } item_t;

    row_t              tbl[$];
    item_t             mq[$];
    bit                live;
    logic [ADDR_W-1:0] pc_ctr;
    int                n_chk  = 0;
    int                n_fail = 0;

    function automatic void add(input logic [31:0] mask, input logic [31:0] match,
                                input logic [5:0] op, input byte fmt);
        row_t r;
        r.mask = mask; r.match = match; r.op = op; r.fmt = fmt;
        tbl.push_back(r);
    endfunction

    function automatic void build_tbl();
        add(32'h0000007F, 32'h00000037, OP_LUI,   "U");
        add(32'h0000007F, 32'h00000017, OP_AUIPC, "U");
        add(32'h0000007F, 32'h0000006F, OP_JAL,   "J");
        add(32'h0000707F, 32'h00000067, OP_JALR,  "X");
        add(32'h0000707F, 32'h00000063, OP_BEQ,   "B");
        add(32'h0000707F, 32'h00001063, OP_BNE,   "B");
        add(32'h0000707F, 32'h00004063, OP_BLT,   "B");
        add(32'h0000707F, 32'h00005063, OP_BGE,   "B");
        add(32'h0000707F, 32'h00006063, OP_BLTU,  "B");
        add(32'h0000707F, 32'h00007063, OP_BGEU,  "B");
        add(32'h0000707F, 32'h00000003, OP_LB,    "L");
        add(32'h0000707F, 32'h00001003, OP_LH,    "L");
        add(32'h0000707F, 32'h00002003, OP_LW,    "L");
        add(32'h0000707F, 32'h00004003, OP_LBU,   "L");
        add(32'h0000707F, 32'h00005003, OP_LHU,   "L");
        add(32'h0000707F, 32'h00000023, OP_SB,    "S");
        add(32'h0000707F, 32'h00001023, OP_SH,    "S");
        add(32'h0000707F, 32'h00002023, OP_SW,    "S");
        add(32'h0000707F, 32'h00000013, OP_ADDI,  "I");
        add(32'h0000707F, 32'h00002013, OP_SLTI,  "I");
        add(32'h0000707F, 32'h00003013, OP_SLTIU, "I");
        add(32'h0000707F, 32'h00004013, OP_XORI,  "I");
        add(32'h0000707F, 32'h00006013, OP_ORI,   "I");
        add(32'h0000707F, 32'h00007013, OP_ANDI,  "I");
        add(32'hFE00707F, 32'h00001013, OP_SLLI,  "I");
        add(32'hFE00707F, 32'h00005013, OP_SRLI,  "I");
        add(32'hFE00707F, 32'h40005013, OP_SRAI,  "I");
        add(32'hFE00707F, 32'h00000033, OP_ADD,   "R");
        add(32'hFE00707F, 32'h40000033, OP_SUB,   "R");
        add(32'hFE00707F, 32'h00001033, OP_SLL,   "R");
        add(32'hFE00707F, 32'h00002033, OP_SLT,   "R");
        add(32'hFE00707F, 32'h00003033, OP_SLTU,  "R");
        add(32'hFE00707F, 32'h00004033, OP_XOR,   "R");
        add(32'hFE00707F, 32'h00005033, OP_SRL,   "R");
        add(32'hFE00707F, 32'h40005033, OP_SRA,   "R");
        add(32'hFE00707F, 32'h00006033, OP_OR,    "R");
        add(32'hFE00707F, 32'h00007033, OP_AND,   "R");
    endfunction

    function automatic exp_t ref_dec(input logic [31:0] i);
        exp_t        e;
        bit          wr;
        logic [31:0] imm_i;
        imm_i     = {{20{i[31]}}, i[31:20]};
        e         = '0;
        e.op      = OP_NOP;
        e.cls     = 2'(CL_ROB);
        e.illegal = 1'b1;
        wr        = 1'b0;
        foreach (tbl[k]) begin
            if ((i & tbl[k].mask) == tbl[k].match) begin
                e.illegal = 1'b0;
                e.cls     = 2'(CL_RS);
                e.op      = tbl[k].op;
                case (tbl[k].fmt)
                    "U": begin e.imm = {i[31:12], 12'h000}; wr = 1'b1; end
                    "J": begin e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; wr = 1'b1; end
                    "X": begin e.imm = imm_i; wr = 1'b1; e.rs1_en = 1'b1; end
                    "B": begin
                        e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
                        e.rs1_en = 1'b1; e.rs2_en = 1'b1;
                    end
                    "L": begin e.imm = imm_i; wr = 1'b1; e.rs1_en = 1'b1; e.cls = 2'(CL_LSB); end
                    "S": begin
                        e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
                        e.rs1_en = 1'b1; e.rs2_en = 1'b1; e.cls = 2'(CL_LSB);
                    end
                    "I": begin e.imm = imm_i; wr = 1'b1; e.rs1_en = 1'b1; end
                    default: begin wr = 1'b1; e.rs1_en = 1'b1; e.rs2_en = 1'b1; end
                endcase
            end
        end
        if (e.rs1_en) e.rs1 = i[19:15];
        if (e.rs2_en) e.rs2 = i[24:20];
        if (wr)       e.rd  = i[11:7];
        e.rd_en = wr && (i[11:7] != 5'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model mid-cycle, then advance the model
    task automatic cyc(input bit v, input logic [31:0] inst, input bit rdy, input bit fl,
                       input bit robf, input bit rsf, input bit lsbf);
        exp_t e;
        bit   full, exp_rdy, acc, fire;
        iq_valid = v; iq_inst = inst; iq_pc = pc_ctr;
        rdy_in = rdy; flush_in = fl; rob_full = robf; rs_full = rsf; lsb_full = lsbf;
        #3;
        exp_rdy = live && (mq.size() < DEPTH) && rdy && !fl;
        acc     = v && exp_rdy;
        fire    = 1'b0;
        e       = '0;
        if (mq.size() > 0) begin
            e    = ref_dec(mq[0].inst);
            full = (e.cls == 2'(CL_LSB)) ? lsbf : (e.cls == 2'(CL_RS)) ? rsf : 1'b0;
            fire = rdy && !fl && !robf && !full;
            chk("disp_op",      disp_op,      e.op);
            chk("disp_imm",     disp_imm,     e.imm);
            chk("disp_rd",      disp_rd,      e.rd);
            chk("disp_rd_en",   disp_rd_en,   e.rd_en);
            chk("disp_pc",      disp_pc,      mq[0].pc);
            chk("disp_illegal", disp_illegal, e.illegal);
            chk("rs_fields", {reg_rs1_en, reg_rs1, reg_rs2_en, reg_rs2},
                             {e.rs1_en, e.rs1, e.rs2_en, e.rs2});
        end
        chk("iq_ready",   iq_ready,   exp_rdy);
        chk("disp_valid", disp_valid, fire);
        chk("rob_we",     rob_we,     fire);
        chk("rs_we",      rs_we,      fire && (e.cls == 2'(CL_RS)));
        chk("lsb_we",     lsb_we,     fire && (e.cls == 2'(CL_LSB)));
        @(posedge clk_in);
        live = 1'b1;
        if (rdy && fl) begin
            mq.delete();
        end else begin
            if (fire) void'(mq.pop_front());
            if (acc) begin
                mq.push_back('{inst, pc_ctr});
                pc_ctr = pc_ctr + 4;
            end
        end
        #1;
    endtask

    function automatic logic [31:0] addi(input int rd, input int imm);
        return {12'(imm), 5'd0, 3'b000, 5'(rd), 7'h13};
    endfunction

    function automatic logic [31:0] gen_inst();
        int          k;
        int          sel;
        logic [31:0] r;
        sel = $urandom_range(0, 9);
        r   = $urandom;
        if (sel == 0) return r;
        if (sel == 1) return 32'h0000_0000;
        k = $urandom_range(0, tbl.size() - 1);
        return (r & ~tbl[k].mask) | tbl[k].match;
    endfunction

    initial begin
        build_tbl();
        live   = 1'b0;
        pc_ctr = 32'h0000_1000;
        rst_in = 1'b0; rdy_in = 1'b0; flush_in = 1'b0; iq_valid = 1'b0;
        iq_inst = '0; iq_pc = '0; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        #2;
        chk("reset_outs", {iq_ready, disp_valid, rob_we, rs_we, lsb_we, disp_op, disp_imm,
                           disp_rd, disp_rd_en, disp_pc, disp_illegal, reg_rs1_en,
                           reg_rs2_en, reg_rs1, reg_rs2}, '0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;

        // First cycle after release: not ready yet
        cyc(1'b0, 32'h0, 1, 0, 0, 0, 0);

        // ADDI x1, x0, 5
        cyc(1'b1, 32'h00500093, 1, 0, 0, 0, 0);
        chk("addi_op",   disp_op,    OP_ADDI);
        chk("addi_imm",  disp_imm,   32'd5);
        chk("addi_rd",   {disp_rd, disp_rd_en}, {5'd1, 1'b1});
        chk("addi_rs1",  {reg_rs1_en, reg_rs1}, {1'b1, 5'd0});
        chk("addi_strb", {disp_valid, rob_we, rs_we, lsb_we}, 4'b1110);
        cyc(1'b0, 32'h0, 1, 0, 0, 0, 0);

        // LW x2, -4(x1) held back by lsb_full
        cyc(1'b1, 32'hFFC0A103, 1, 0, 0, 0, 1);
        chk("lw_op",  disp_op,  OP_LW);
        chk("lw_imm", disp_imm, 32'hFFFF_FFFC);
        chk("lw_rd",  disp_rd,  5'd2);
        chk("lw_rs1", reg_rs1,  5'd1);
        for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1, 0, 0, 0, 1);
        cyc(1'b0, 32'h0, 1, 0, 0, 0, 0);

        // rob_full: fill buffer, ready drops, then drain in PC order
        for (int k = 0; k < DEPTH; k++) cyc(1'b1, addi(k + 3, k + 10), 1, 0, 1, 0, 0);
        chk("full_ready", iq_ready, 1'b0);
        cyc(1'b1, addi(9, 9), 1, 0, 1, 0, 0);
        for (int k = 0; k < DEPTH; k++) cyc(1'b0, 32'h0, 1, 0, 0, 0, 0);
        chk("drained", disp_valid, 1'b0);

        // Flush with an offered instruction
        cyc(1'b1, addi(4, 1), 1, 0, 1, 0, 0);
        cyc(1'b1, addi(5, 2), 1, 0, 1, 0, 0);
        cyc(1'b1, addi(6, 3), 1, 1, 1, 0, 0);
        chk("flush_empty", disp_valid, 1'b0);
        cyc(1'b0, 32'h0, 1, 0, 0, 0, 0);
        cyc(1'b1, addi(7, 4), 1, 0, 0, 0, 0);
        cyc(1'b0, 32'h0, 1, 0, 0, 0, 0);

        // Illegal all-zero instruction
        cyc(1'b1, 32'h0000_0000, 1, 0, 0, 1, 1);
        chk("ill_flags", {disp_illegal, disp_op, disp_rd_en}, {1'b1, OP_NOP, 1'b0});
        chk("ill_strb",  {disp_valid, rob_we, rs_we, lsb_we}, 4'b1100);
        cyc(1'b0, 32'h0, 1, 0, 0, 0, 0);

        // Asynchronous reset mid-stream
        cyc(1'b1, 32'hFFC0A103, 1, 0, 1, 0, 0);
        cyc(1'b1, addi(8, 8), 1, 0, 1, 0, 0);
        #1;
        rst_in = 1'b0;
        #1;
        chk("midrst_outs", {iq_ready, disp_valid, rob_we, rs_we, lsb_we, disp_op, disp_imm,
                            disp_rd, disp_rd_en, disp_pc, disp_illegal, reg_rs1_en,
                            reg_rs2_en, reg_rs1, reg_rs2}, '0);
        mq.delete();
        live = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        cyc(1'b1, addi(1, 1), 1, 0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 3) != 0), gen_inst(),
                ($urandom_range(0, 7) != 0), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 4) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 Parameter DEPTH, default 2, decoded-entry buffer depth; power of two, >=2.
REQ-002 Parameter ADDR_W, default 32, PC width.
REQ-003 Parameter OP_W, default 6, internal opcode width (shared package OpBus).
REQ-004 Clocking SHALL be: one clock clk_in, all state on its rising edge; reset rst_in is asynchronous and active-low.
REQ-005 clk_in  in  1  clock.
REQ-006 rst_in  in  1  async active-low reset.
REQ-007 rdy_in  in  1  global enable; low freezes all state.
REQ-008 flush_in  in  1  misprediction clear.
REQ-009 iq_valid  in  1  instruction offered.
REQ-010 iq_inst  in  32  raw instruction.
REQ-011 iq_pc  in  ADDR_W  instruction PC.
REQ-012 iq_ready  out  1  entry accepted when iq_valid&iq_ready.
REQ-013 rob_full / rs_full / lsb_full  in  1 each  downstream full flags.
REQ-014 reg_rs1_en, reg_rs2_en  out  1  regfile read enables; reg_rs1, reg_rs2  out  5  read indices.
REQ-015 disp_valid  out  1  head entry dispatched this cycle.
REQ-016 disp_op  out  OP_W; disp_imm  out  32; disp_rd  out  5; disp_rd_en  out  1; disp_pc  out  ADDR_W; disp_illegal  out  1.
REQ-017 rob_we, rs_we, lsb_we  out  1  allocation strobes.

Function
REQ-018 Decode SHALL be combinational on iq_inst; decoded fields written into tail entry on accept edge.
REQ-019 iq_ready SHALL equal (count<DEPTH) & rdy_in & ~flush_in; no same-cycle bypass when full.
REQ-020 Immediates SHALL be sign-extended per RV32I formats: U {inst[31:12],12'b0}; J, B with bit0=0; I {inst[31:20]}; S {inst[31:25],inst[11:7]}; R zero.
REQ-021 Register reads SHALL be driven from head entry: rs1 enabled for JALR/B/load/store/OP-IMM/OP, rs2 for B/store/OP; disabled indices read 0.
REQ-022 disp_rd_en SHALL be 1 only for rd-writing formats with rd!=0.
REQ-023 Head class: load/store -> LSB, illegal -> ROB only, all else -> RS.
REQ-024 Dispatch SHALL fire when count>0 & rdy_in & ~flush_in & ~rob_full & ~(target full); then disp_valid=1, rob_we=1, rs_we/lsb_we one-hot per class, head pops at edge.
REQ-025 Earliest dispatch SHALL be the cycle after the accept edge (1-cycle latency); order strictly FIFO.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-027 Unknown opcode or funct3/funct7 SHALL set disp_illegal=1, disp_op=NOP, rd_en=0.
REQ-028 flush_in SHALL clear count and pointers at the edge; same-cycle push and pop suppressed.
REQ-029 When not dispatching, disp_valid, rob_we, rs_we, lsb_we SHALL be 0; data outputs hold head contents.

Reset
REQ-030 rst_in low SHALL immediately zero pointers, count, all entries and all outputs; iq_ready rises first edge after release.
REQ-031 Reset mid-operation SHALL discard buffered entries without emitting any strobe.

Structure
REQ-032 Shared package SHALL hold RV32I opcode constants, internal op codes incl. NOP, OP_W, widths.
REQ-033 Sub-module id_decode (combinational: inst -> op, imm, rd, rd_en, rs enables, class, illegal) SHALL be instantiated once.

Verification
REQ-034 0x00500093 accepted -> next cycle disp_op=ADDI, imm=5, rd=1, rd_en=1, rs1_en=1 rs1=0, rob_we=rs_we=1, lsb_we=0.
REQ-035 0xFFC0A103 -> LW, imm=0xFFFFFFFC, rd=2, rs1=1, lsb_we=1, rs_we=0; with lsb_full=1 held until release.
REQ-036 rob_full=1, push DEPTH instrs -> iq_ready=0; release -> dispatched in PC order one per cycle.
REQ-037 Two entries buffered, flush_in with iq_valid=1 -> count 0, disp_valid=0 next cycle, pushed inst absent.
REQ-038 0x00000000 -> disp_illegal=1, rob_we=1, rs_we=lsb_we=0; rst_in low mid-stream -> all outputs 0 asynchronously.
